// File: rtl/hilo_writer_pkg.sv
// Shared types and constants for the HI/LO writer.
package hilo_writer_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_MUL  = 2'd1,
    OP_DIV  = 2'd2,
    OP_MT   = 2'd3
  } op_class_e;

endpackage

// File: rtl/hilo_writer_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module hilo_writer_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_div,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);
  import hilo_writer_pkg::*;

  logic [XLEN:0]   w_shift;
  logic [XLEN+1:0] w_diff;
  logic            w_borrow;

  // The quotient register doubles as the dividend shift register, so its MSB is the next bit in.
  assign w_shift  = {i_rem, i_quo[XLEN-1]};
  assign w_diff   = {1'b0, w_shift} - {2'b00, i_div};
  assign w_borrow = w_diff[XLEN+1];

  // Restore on borrow, otherwise keep the difference and record a quotient one.
  always_comb begin
    o_rem = w_diff[XLEN-1:0];
    if (w_borrow) begin
      o_rem = w_shift[XLEN-1:0];
    end else begin
      o_rem = w_diff[XLEN-1:0];
    end
    o_quo = {i_quo[XLEN-2:0], ~w_borrow};
  end

endmodule

// File: rtl/hilo_writer.sv
// HI/LO owner: iterative MULT/MULTU/DIV/DIVU plus single-cycle MTHI/MTLO.
// Optional HILO_FAST_MULT_EN: multiply resolves in one MUL cycle instead of ITERS.
module hilo_writer #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            is_mult,
  input  logic            is_multu,
  input  logic            is_div,
  input  logic            is_divu,
  input  logic            is_mthi,
  input  logic            is_mtlo,
  input  logic [XLEN-1:0] rs_value,
  input  logic [XLEN-1:0] rt_value,
  output logic [XLEN-1:0] reg_hi,
  output logic [XLEN-1:0] reg_lo,
  output logic            busy
);
  import hilo_writer_pkg::*;

  localparam int            CW      = $clog2(ITERS);
  localparam logic [CW-1:0] LAST    = CW'(ITERS - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_e            r_state, w_state_nx;
  op_class_e         w_op;
  logic              w_signed, w_mul_last;
  logic [CW-1:0]     r_count;
  logic [XLEN-1:0]   r_hi, r_lo, r_a, r_b, r_acc;
  logic              r_neg_q, r_neg_r, r_div0, r_busy;
  logic [XLEN-1:0]   w_rs_mag, w_rt_mag;
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN-1:0]   w_mul_acc_nx, w_mul_b_nx, w_div_rem_nx, w_div_quo_nx;
  logic [2*XLEN-1:0] w_prod, w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix, w_rem_fix;

  // Strobe decode: divide beats multiply beats move, signed beats unsigned.
  always_comb begin
    w_op     = OP_NONE;
    w_signed = 1'b0;
    if (is_div || is_divu) begin
      w_op     = OP_DIV;
      w_signed = is_div;
    end else if (is_mult || is_multu) begin
      w_op     = OP_MUL;
      w_signed = is_mult;
    end else if (is_mthi || is_mtlo) begin
      w_op = OP_MT;
    end else begin
      w_op = OP_NONE;
    end
  end

  assign w_rs_mag = (w_signed && rs_value[XLEN-1]) ? -rs_value : rs_value;
  assign w_rt_mag = (w_signed && rt_value[XLEN-1]) ? -rt_value : rt_value;

  // Shift-add: {r_acc, r_b} holds the growing product, r_b's LSB selects the add.
  assign w_mul_sum    = {1'b0, r_acc} + (r_b[0] ? {1'b0, r_a} : {(XLEN+1){1'b0}});
  assign w_mul_acc_nx = w_mul_sum[XLEN:1];
  assign w_mul_b_nx   = {w_mul_sum[0], r_b[XLEN-1:1]};

`ifdef HILO_FAST_MULT_EN
  assign w_mul_last = 1'b1;
  assign w_prod     = {{XLEN{1'b0}}, r_a} * {{XLEN{1'b0}}, r_b};
`else
  assign w_mul_last = (r_count == LAST);
  assign w_prod     = {w_mul_acc_nx, w_mul_b_nx};
`endif

  hilo_writer_div_step #(.XLEN(XLEN)) u_div_step (
    .i_rem (r_acc),
    .i_quo (r_b),
    .i_div (r_a),
    .o_rem (w_div_rem_nx),
    .o_quo (w_div_quo_nx)
  );

  // A zero divisor leaves |dividend| as remainder, so only the quotient needs overriding.
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  assign w_quo_fix  = r_div0 ? DIV0_QUOT : (r_neg_q ? -w_div_quo_nx : w_div_quo_nx);
  assign w_rem_fix  = r_neg_r ? -w_div_rem_nx : w_div_rem_nx;

  // Next-state selection.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE: begin
        if (w_op == OP_DIV) begin
          w_state_nx = DIV;
        end else if (w_op == OP_MUL) begin
          w_state_nx = MUL;
        end else begin
          w_state_nx = IDLE;
        end
      end
      MUL:     w_state_nx = w_mul_last ? IDLE : MUL;
      DIV:     w_state_nx = (r_count == LAST) ? IDLE : DIV;
      default: w_state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Operand latch, iteration, commit and MT writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= {CW{1'b0}};
      r_hi    <= {XLEN{1'b0}};
      r_lo    <= {XLEN{1'b0}};
      r_a     <= {XLEN{1'b0}};
      r_b     <= {XLEN{1'b0}};
      r_acc   <= {XLEN{1'b0}};
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_count <= {CW{1'b0}};
          case (w_op)
            OP_MUL, OP_DIV: begin
              r_a     <= w_rt_mag;
              r_b     <= w_rs_mag;
              r_acc   <= {XLEN{1'b0}};
              r_neg_q <= w_signed & (rs_value[XLEN-1] ^ rt_value[XLEN-1]);
              r_neg_r <= w_signed & rs_value[XLEN-1];
              r_div0  <= (rt_value == {XLEN{1'b0}});
              r_busy  <= 1'b1;
            end
            OP_MT: begin
              if (is_mthi) r_hi <= rs_value;
              if (is_mtlo) r_lo <= rs_value;
            end
            default: r_busy <= 1'b0;
          endcase
        end
        MUL: begin
          r_acc   <= w_mul_acc_nx;
          r_b     <= w_mul_b_nx;
          r_count <= r_count + CNT_ONE;
          if (w_mul_last) begin
            r_hi   <= w_prod_fix[2*XLEN-1:XLEN];
            r_lo   <= w_prod_fix[XLEN-1:0];
            r_busy <= 1'b0;
          end
        end
        DIV: begin
          r_acc   <= w_div_rem_nx;
          r_b     <= w_div_quo_nx;
          r_count <= r_count + CNT_ONE;
          if (r_count == LAST) begin
            r_hi   <= w_rem_fix;
            r_lo   <= w_quo_fix;
            r_busy <= 1'b0;
          end
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign reg_hi = r_hi;
  assign reg_lo = r_lo;
  assign busy   = r_busy;

endmodule
